// File: rtl/sdc_spi_responder.sv
// SD-card side of the SPI-mode init link: receives 6-byte command frames,
// tracks the CMD0/CMD8/CMD55/ACMD41/CMD58 init state and shifts out
// R1/R3/R7 responses, byte-aligned after NCR filler bytes.
module sdc_spi_responder #(
    parameter int          IDLE_POLLS = 3,
    parameter int          NCR        = 1,
    parameter logic [31:0] OCR        = 32'hC0FF8000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_sck,
    input  logic        i_cs,
    input  logic        i_mosi,
    output logic        o_miso,
    output logic        o_cmd_valid,
    output logic [5:0]  o_cmd_index,
    output logic [31:0] o_cmd_arg,
    output logic        o_idle
);

    localparam int            PW       = $clog2(IDLE_POLLS + 2);
    localparam logic [PW-1:0] POLL_MAX = PW'(IDLE_POLLS);
    localparam logic [3:0]    GAP_LAST = 4'(NCR - 1);

    typedef enum logic [1:0] {HUNT, CMD, GAP, RESP} state_e;

    // Two-stage synchronisers plus previous-SCK register for edge detection
    logic [1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
    logic       sck_prev_q;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sck_sync_q  <= 2'b00;
            cs_sync_q   <= 2'b11;
            mosi_sync_q <= 2'b11;
            sck_prev_q  <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[0], i_sck};
            cs_sync_q   <= {cs_sync_q[0], i_cs};
            mosi_sync_q <= {mosi_sync_q[0], i_mosi};
            sck_prev_q  <= sck_sync_q[1];
        end
    end

    logic sck_rise, sck_fall, cs_n, mosi;
    assign sck_rise = sck_sync_q[1] & ~sck_prev_q;
    assign sck_fall = ~sck_sync_q[1] & sck_prev_q;
    assign cs_n     = cs_sync_q[1];
    assign mosi     = mosi_sync_q[1];

    state_e        state_q, state_d;
    logic [6:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [2:0]    byte_idx_q, byte_idx_d;
    logic [5:0]    idx_q, idx_d;
    logic [31:0]   arg_q, arg_d;
    logic [3:0]    gap_cnt_q, gap_cnt_d;
    logic [5:0]    rbit_q, rbit_d;
    logic [39:0]   resp_q, resp_d;
    logic [2:0]    len_q, len_d;
    logic          miso_q, miso_d;
    logic          valid_q, valid_d;
    logic [5:0]    out_idx_q, out_idx_d;
    logic [31:0]   out_arg_q, out_arg_d;
    logic          idle_q, idle_d;
    logic [PW-1:0] poll_q, poll_d;
    logic          app_q, app_d;

    logic [7:0]    byte_in;
    logic          byte_done;
    assign byte_in   = {shift_q, mosi};
    assign byte_done = sck_rise && (bit_cnt_q == 3'd7);

    // Command decode: response buffer and init-state updates for the held frame
    logic [7:0]    r1;
    logic [39:0]   dec_resp;
    logic [2:0]    dec_len;
    logic          dec_idle;
    logic [PW-1:0] dec_poll;

    always_comb begin
        dec_idle = idle_q;
        dec_poll = poll_q;
        dec_len  = 3'd1;
        r1       = {7'b0, idle_q};
        case (idx_q)
            6'd0: begin
                dec_idle = 1'b1;
                dec_poll = '0;
                r1       = 8'h01;
            end
            6'd8, 6'd55, 6'd58: ;
            6'd41: begin
                if (!app_q) begin
                    r1 = {5'b0, 1'b1, 1'b0, idle_q};
                end else if (poll_q < POLL_MAX) begin
                    r1       = 8'h01;
                    dec_poll = poll_q + PW'(1);
                end else begin
                    dec_idle = 1'b0;
                    r1       = 8'h00;
                end
            end
            default: r1 = {5'b0, 1'b1, 1'b0, idle_q};
        endcase
        dec_resp = {r1, 32'hFFFF_FFFF};
        if (idx_q == 6'd8) begin
            dec_resp = {r1, 16'h0000, 4'h0, arg_q[11:8], arg_q[7:0]};
            dec_len  = 3'd5;
        end else if (idx_q == 6'd58) begin
            dec_resp = {r1, OCR};
            dec_len  = 3'd5;
        end
    end

    // Frame FSM: byte assembly, filler gap and falling-edge response shifter
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        byte_idx_d = byte_idx_q;
        idx_d      = idx_q;
        arg_d      = arg_q;
        gap_cnt_d  = gap_cnt_q;
        rbit_d     = rbit_q;
        resp_d     = resp_q;
        len_d      = len_q;
        miso_d     = miso_q;
        valid_d    = 1'b0;
        out_idx_d  = out_idx_q;
        out_arg_d  = out_arg_q;
        idle_d     = idle_q;
        poll_d     = poll_q;
        app_d      = app_q;
        if (cs_n) begin
            // Deselect drops any partial frame or pending response
            state_d   = HUNT;
            bit_cnt_d = 3'd0;
            miso_d    = 1'b1;
        end else begin
            if (sck_rise) begin
                shift_d   = byte_in[6:0];
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
            unique case (state_q)
                HUNT: if (byte_done && byte_in[7:6] == 2'b01) begin
                    idx_d      = byte_in[5:0];
                    byte_idx_d = 3'd1;
                    state_d    = CMD;
                end
                CMD: if (byte_done) begin
                    if (byte_idx_q == 3'd5) begin
                        // CRC byte is consumed but never checked
                        valid_d   = 1'b1;
                        out_idx_d = idx_q;
                        out_arg_d = arg_q;
                        idle_d    = dec_idle;
                        poll_d    = dec_poll;
                        app_d     = (idx_q == 6'd55);
                        resp_d    = dec_resp;
                        len_d     = dec_len;
                        rbit_d    = 6'd0;
                        gap_cnt_d = 4'd0;
                        state_d   = GAP;
                    end else begin
                        arg_d      = {arg_q[23:0], byte_in};
                        byte_idx_d = byte_idx_q + 3'd1;
                    end
                end
                GAP: if (byte_done) begin
                    if (gap_cnt_q == GAP_LAST) state_d = RESP;
                    else gap_cnt_d = gap_cnt_q + 4'd1;
                end
                RESP: if (sck_fall) begin
                    // The fall after the last sampled bit releases MISO high
                    if (rbit_q == {len_q, 3'b000}) begin
                        miso_d  = 1'b1;
                        state_d = HUNT;
                    end else begin
                        miso_d = resp_q[39];
                        resp_d = {resp_q[38:0], 1'b1};
                        rbit_d = rbit_q + 6'd1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // State registers
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= HUNT;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            byte_idx_q <= '0;
            idx_q      <= '0;
            arg_q      <= '0;
            gap_cnt_q  <= '0;
            rbit_q     <= '0;
            resp_q     <= '1;
            len_q      <= 3'd1;
            miso_q     <= 1'b1;
            valid_q    <= 1'b0;
            out_idx_q  <= '0;
            out_arg_q  <= '0;
            idle_q     <= 1'b1;
            poll_q     <= '0;
            app_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_idx_q <= byte_idx_d;
            idx_q      <= idx_d;
            arg_q      <= arg_d;
            gap_cnt_q  <= gap_cnt_d;
            rbit_q     <= rbit_d;
            resp_q     <= resp_d;
            len_q      <= len_d;
            miso_q     <= miso_d;
            valid_q    <= valid_d;
            out_idx_q  <= out_idx_d;
            out_arg_q  <= out_arg_d;
            idle_q     <= idle_d;
            poll_q     <= poll_d;
            app_q      <= app_d;
        end
    end

    assign o_miso      = miso_q;
    assign o_cmd_valid = valid_q;
    assign o_cmd_index = out_idx_q;
    assign o_cmd_arg   = out_arg_q;
    assign o_idle      = idle_q;

endmodule

// File: tb/tb_sdc_spi_responder.sv
// Directed bench for sdc_spi_responder: table of command frames with
// hand-computed responses, plus sequences for reset, CS abort and partial frames.
module tb_sdc_spi_responder;

    localparam int NCR        = 1;
    localparam int IDLE_POLLS = 3;

    logic        i_clk, i_rst, i_sck, i_cs, i_mosi;
    logic        o_miso, o_cmd_valid, o_idle;
    logic [5:0]  o_cmd_index;
    logic [31:0] o_cmd_arg;

    sdc_spi_responder #(.IDLE_POLLS(IDLE_POLLS), .NCR(NCR), .OCR(32'hC0FF8000)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_sck(i_sck), .i_cs(i_cs), .i_mosi(i_mosi),
        .o_miso(o_miso), .o_cmd_valid(o_cmd_valid), .o_cmd_index(o_cmd_index),
        .o_cmd_arg(o_cmd_arg), .o_idle(o_idle)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_chk  = 0;
    int n_fail = 0;
    int vtot   = 0;

    // Count o_cmd_valid cycles (pulse width included)
    always @(negedge i_clk) if (o_cmd_valid) vtot <= vtot + 1;

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [7:0]  crc;
        int          nb;
        logic [39:0] rsp;
        logic        idle;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc,
                       input int nb, input logic [39:0] rsp, input logic idle);
        vec_t v;
        v.idx = idx; v.arg = arg; v.crc = crc; v.nb = nb; v.rsp = rsp; v.idle = idle;
        tbl.push_back(v);
    endtask

    task automatic add1(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc,
                        input logic [7:0] r1, input logic idle);
        add(idx, arg, crc, 1, {r1, 32'h0}, idle);
    endtask

    // One SPI mode-0 bit: set MOSI, sample MISO, rising then falling SCK
    task automatic xbit(input logic b, output logic r);
        i_mosi = b;
        #50;
        r = o_miso;
        i_sck = 1'b1;
        #50;
        i_sck = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) xbit(tx[i], rx[i]);
    endtask

    task automatic send_frame(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc);
        logic [7:0] rx;
        xfer({2'b01, idx}, rx);
        for (int b = 3; b >= 0; b--) xfer(arg[8*b +: 8], rx);
        xfer(crc, rx);
    endtask

    task automatic run_cmd(input vec_t v, input string tag);
        logic [7:0]  rx;
        logic [39:0] r;
        int          base;
        base = vtot;
        send_frame(v.idx, v.arg, v.crc);
        for (int g = 0; g < NCR; g++) begin
            xfer(8'hFF, rx);
            chk({tag, " gap"}, 40'(rx), 40'hFF);
        end
        r = v.rsp;
        for (int b = 0; b < v.nb; b++) begin
            xfer(8'hFF, rx);
            chk($sformatf("%s rsp%0d", tag, b), 40'(rx), 40'(r[39:32]));
            r = r << 8;
        end
        xfer(8'hFF, rx);
        chk({tag, " tail"}, 40'(rx), 40'hFF);
        chk({tag, " valid"}, 40'(vtot - base), 40'd1);
        chk({tag, " index"}, 40'(o_cmd_index), 40'(v.idx));
        chk({tag, " arg"}, 40'(o_cmd_arg), 40'(v.arg));
        chk({tag, " idle"}, 40'(o_idle), 40'(v.idle));
    endtask

    initial begin
        vec_t       w;
        logic [7:0] rx;
        logic       rb;
        int         base;

        // Stimulus table: {cmd, arg, crc, response bytes, idle afterwards}
        add1(6'd0, 32'h0, 8'h95, 8'h01, 1'b1);
        add(6'd8, 32'h0000_01AA, 8'h87, 5, 40'h01_00_00_01_AA, 1'b1);
        add1(6'd41, 32'h4000_0000, 8'h01, 8'h05, 1'b1);
        for (int k = 0; k < 3; k++) begin
            add1(6'd55, 32'h0, 8'h01, 8'h01, 1'b1);
            add1(6'd41, 32'h4000_0000, 8'h01, 8'h01, 1'b1);
        end
        add1(6'd55, 32'h0, 8'h01, 8'h01, 1'b1);
        add1(6'd41, 32'h4000_0000, 8'h01, 8'h00, 1'b0);
        add(6'd58, 32'h0, 8'h01, 5, 40'h00_C0_FF_80_00, 1'b0);
        add1(6'd2, 32'h0, 8'h01, 8'h04, 1'b0);
        add1(6'd55, 32'h0, 8'h01, 8'h00, 1'b0);
        add1(6'd41, 32'h4000_0000, 8'h01, 8'h00, 1'b0);
        add1(6'd0, 32'h0, 8'h95, 8'h01, 1'b1);
        add(6'd8, 32'hFFFF_F5A5, 8'h01, 5, 40'h01_00_00_05_A5, 1'b1);
        add1(6'd55, 32'h0, 8'h01, 8'h01, 1'b1);
        add1(6'd17, 32'h0, 8'h01, 8'h05, 1'b1);
        add1(6'd41, 32'h4000_0000, 8'h01, 8'h05, 1'b1);
        for (int k = 0; k < 3; k++) begin
            add1(6'd55, 32'h0, 8'h01, 8'h01, 1'b1);
            add1(6'd41, 32'h4000_0000, 8'h01, 8'h01, 1'b1);
        end
        add1(6'd55, 32'h0, 8'h01, 8'h01, 1'b1);
        add1(6'd41, 32'h4000_0000, 8'h01, 8'h00, 1'b0);

        i_rst = 1'b0; i_cs = 1'b1; i_sck = 1'b0; i_mosi = 1'b1;
        #42;
        chk("reset miso", 40'(o_miso), 40'd1);
        chk("reset valid", 40'(o_cmd_valid), 40'd0);
        chk("reset index", 40'(o_cmd_index), 40'd0);
        chk("reset arg", 40'(o_cmd_arg), 40'd0);
        chk("reset idle", 40'(o_idle), 40'd1);
        #20 i_rst = 1'b1;
        #100 i_cs = 1'b0;
        #100;

        foreach (tbl[k]) run_cmd(tbl[k], $sformatf("v%0d", k));

        // Reset in the middle of the CMD58 R1 byte (all zero bits)
        send_frame(6'd58, 32'h0, 8'hFD);
        xfer(8'hFF, rx);
        for (int i = 0; i < 4; i++) xbit(1'b1, rb);
        #50;
        chk("pre-reset miso", 40'(o_miso), 40'd0);
        i_rst = 1'b0;
        #1;
        chk("async reset miso", 40'(o_miso), 40'd1);
        chk("async reset idle", 40'(o_idle), 40'd1);
        chk("async reset index", 40'(o_cmd_index), 40'd0);
        chk("async reset arg", 40'(o_cmd_arg), 40'd0);
        #9;
        i_cs = 1'b1;
        #100 i_rst = 1'b1;
        #100 i_cs = 1'b0;
        #100;
        w = '{idx: 6'd55, arg: 32'h0, crc: 8'h01, nb: 1, rsp: 40'h01_0000_0000, idle: 1'b1};
        run_cmd(w, "post-reset cmd55");
        w = '{idx: 6'd41, arg: 32'h4000_0000, crc: 8'h01, nb: 1, rsp: 40'h01_0000_0000, idle: 1'b1};
        run_cmd(w, "post-reset acmd41");

        // CS raised mid-response while MISO drives a zero bit
        base = vtot;
        send_frame(6'd8, 32'h0000_01AA, 8'h87);
        xfer(8'hFF, rx);
        xfer(8'hFF, rx);
        chk("abort r1", 40'(rx), 40'h01);
        for (int i = 0; i < 4; i++) xbit(1'b1, rb);
        #50;
        chk("abort pre miso", 40'(o_miso), 40'd0);
        i_cs = 1'b1;
        #50;
        chk("cs high miso", 40'(o_miso), 40'd1);
        chk("abort valid", 40'(vtot - base), 40'd1);
        #100 i_cs = 1'b0;
        #100;
        w = '{idx: 6'd55, arg: 32'h0, crc: 8'h01, nb: 1, rsp: 40'h01_0000_0000, idle: 1'b1};
        run_cmd(w, "after abort");

        // Partial frame (3 bytes) discarded by CS high, then a clean CMD0
        base = vtot;
        xfer(8'h40, rx);
        xfer(8'h00, rx);
        xfer(8'h00, rx);
        i_cs = 1'b1;
        #50;
        chk("partial miso", 40'(o_miso), 40'd1);
        #100;
        chk("partial valid", 40'(vtot - base), 40'd0);
        i_cs = 1'b0;
        #100;
        w = '{idx: 6'd0, arg: 32'h0, crc: 8'h95, nb: 1, rsp: 40'h01_0000_0000, idle: 1'b1};
        run_cmd(w, "clean cmd0");

        i_cs = 1'b1;
        #100;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
